sprite_draw_engine: RTL and testbench
=====================================

Name: sprite_draw_engine

Overview:
- Converts tile-level draw commands into a per-pixel plot stream for the VGA frame-buffer adapter (x, y, colour, plot).
- Sits between the game controller and the adapter. The controller issues one command per 5x5 tile; this block walks the 25 pixels.
- Has a one-entry command slot, so the controller can queue the next tile while the current one draws.

Parameters:
- TILE, 5, tile edge in pixels. Only 5 is supported; shape width is TILE*TILE.
- MAX_TX, 31, largest legal tile column; screen x = 0..159.
- MAX_TY, 23, largest legal tile row; screen y = 0..119.

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  slot empty; command accepted when cmd_valid & cmd_ready
- cmd_tx  in  5  tile column
- cmd_ty  in  5  tile row
- cmd_shape  in  25  bitmap; bit 24 = row0/col0, bit (24-(5*row+col)) = pixel (row,col)
- cmd_colour  in  3  foreground colour
- cmd_erase  in  1  draw all 25 pixels as 3'b000
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot_en  out  1  write strobe to adapter
- done  out  1  one-cycle pulse after a command's last pixel
- cmd_err  out  1  one-cycle pulse when an out-of-range command is dropped

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is synchronous and active-low.
- Reset values: x=0, y=0, colour=0, plot_en=0, done=0, cmd_err=0, slot empty, FSM=IDLE, pixel counter=0.
- Reset mid-draw: abort immediately; any pending command is discarded.
- Command slot:
  - cmd_ready = !slot_full.
  - An accept at cycle T sets slot_full from T+1.
  - The slot is freed in the cycle the FSM pops it.
  - When the slot is popped and written in the same cycle, it stays full with the new command.
- FSM states:
  - IDLE: if slot_full, pop the slot. Latch base_x = tx*5, base_y = ty*5, shape, colour and erase. Go to DRAW.
  - DRAW: counter (row,col) runs 0..4 col-major-inner, identical to existing 5x5 walk order: col increments, and on col==4 resets with row++. After (4,4), go to DONE.
  - DONE: done is asserted on the outputs next cycle. If slot_full, pop and go to DRAW; else go to IDLE.
- Range check at pop: if tx>MAX_TX or ty>MAX_TY:
  - no DRAW;
  - cmd_err pulses one cycle later;
  - FSM returns to IDLE;
  - done is not asserted.
- Outputs are registered, one cycle after the DRAW counter value:
  - x = base_x + col; y = base_y + row.
  - colour = erase ? 0 : (shape bit ? cmd colour : 0).
  - plot_en = 1 for all 25 DRAW cycles.
- Widths: tx*5 is computed into 8 bits (max 155+4=159) and ty*5 into 7 bits (max 115+4=119); no wrap is possible for legal ranges.
- Timing for a command accepted at cycle T with FSM idle:
  - plot_en high at T+3..T+27 (exactly 25 cycles);
  - done high at T+28 only.
- Back-to-back commands: exactly one non-plot cycle between consecutive sprites, and it coincides with the done pulse.
- x, y and colour hold their last values while plot_en=0.

Optional Feature:
- SPRITE_TRANSPARENT_EN:
  - Defined: when erase=0, pixels whose shape bit is 0 drive plot_en=0 in their cycle, so the background is preserved. Timing is unchanged (still 25 cycles); erase commands plot all 25.
  - Undefined: zero bits plot colour 3'b000, as above.

Test Plan:
- Reset, then cmd tx=2, ty=3, shape=all ones, colour=3'b110 at T -> plot_en at T+3..T+27; first pixel (10,15), last (14,19); all colour 110; done at T+28 only.
- shape=25'h1000001 (corners row0/col0 and row4/col4), colour=3'b010 -> pixel 0 colour 010, pixels 1..23 colour 000, pixel 24 colour 010. With SPRITE_TRANSPARENT_EN, exactly 2 plot_en cycles, at T+3 and T+27.
- cmd_erase=1, shape=all ones -> 25 plots, all colour 000, done at T+28.
- Two commands with cmd_valid held: second accepted at T+2, cmd_ready low while slot full; second sprite plots T+29..T+53 with plot_en=0 and done=1 at T+28; done again at T+54.
- Boundary and error: tx=31, ty=23 -> last pixel (159,119). ty=24 -> no plot_en, cmd_err one pulse, no done, cmd_ready recovers.
- Reset asserted at T+10 of a draw with a second command pending -> next cycle all outputs 0, cmd_ready=1, no further plots or done.

Source files
------------

// File: rtl/sprite_draw_engine_if.sv
// Command and pixel-stream bundle between the game controller, sprite_draw_engine
// and the VGA frame-buffer adapter.
interface sprite_draw_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_tx;
    logic [4:0]  cmd_ty;
    logic [24:0] cmd_shape;
    logic [2:0]  cmd_colour;
    logic        cmd_erase;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot_en;
    logic        done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_tx, cmd_ty, cmd_shape, cmd_colour, cmd_erase,
        input  cmd_ready, x, y, colour, plot_en, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_tx, cmd_ty, cmd_shape, cmd_colour, cmd_erase,
        output cmd_ready, x, y, colour, plot_en, done, cmd_err
    );
endinterface

// File: rtl/sprite_draw_engine.sv
// Walks one 5x5 tile command per sprite into a registered per-pixel plot stream.
// Optional macro SPRITE_TRANSPARENT_EN: zero shape bits suppress plot_en instead of plotting black.
module sprite_draw_engine #(
    parameter int TILE   = 5,
    parameter int MAX_TX = 31,
    parameter int MAX_TY = 23
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sprite_draw_engine_if.slave  bus
);
    localparam int         NPIX = TILE * TILE;
    localparam logic [2:0] LAST = 3'(TILE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [7:0]      base_x_q, base_x_d;
    logic [6:0]      base_y_q, base_y_d;
    logic [NPIX-1:0] shape_q, shape_d;
    logic [2:0]      fg_q, fg_d;
    logic            erase_q, erase_d;

    logic            slot_full_q, slot_full_d;
    logic [4:0]      slot_tx_q, slot_tx_d;
    logic [4:0]      slot_ty_q, slot_ty_d;
    logic [NPIX-1:0] slot_shape_q, slot_shape_d;
    logic [2:0]      slot_colour_q, slot_colour_d;
    logic            slot_erase_q, slot_erase_d;

    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      pix_colour_q, pix_colour_d;
    logic            plot_q, plot_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            pop;
    logic            in_range;
    logic [5:0]      tx_margin;
    logic [5:0]      ty_margin;
`ifdef SPRITE_TRANSPARENT_EN
    logic            pix_on;
`endif

    always_comb begin
        accept    = bus.cmd_valid & ~slot_full_q;
        pop       = slot_full_q & ((state_q == S_IDLE) | (state_q == S_DONE));
        // A borrow out of (limit - coord) means the coordinate is past the limit.
        tx_margin = 6'(MAX_TX) - {1'b0, slot_tx_q};
        ty_margin = 6'(MAX_TY) - {1'b0, slot_ty_q};
        in_range  = ~tx_margin[5] & ~ty_margin[5];

        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        shape_d       = shape_q;
        fg_d          = fg_q;
        erase_d       = erase_q;
        slot_tx_d     = slot_tx_q;
        slot_ty_d     = slot_ty_q;
        slot_shape_d  = slot_shape_q;
        slot_colour_d = slot_colour_q;
        slot_erase_d  = slot_erase_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_colour_d  = pix_colour_q;
        plot_d        = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        slot_full_d = (slot_full_q & ~pop) | accept;
        if (accept) begin
            slot_tx_d     = bus.cmd_tx;
            slot_ty_d     = bus.cmd_ty;
            slot_shape_d  = bus.cmd_shape;
            slot_colour_d = bus.cmd_colour;
            slot_erase_d  = bus.cmd_erase;
        end

        case (state_q)
            S_DRAW: begin
`ifdef SPRITE_TRANSPARENT_EN
                pix_on = erase_q | shape_q[NPIX-1];
                plot_d = pix_on;
`else
                plot_d = 1'b1;
`endif
                // The current pixel's bit is always the MSB; shift it out as we walk.
                shape_d = shape_q << 1;
                if (col_q == LAST) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                    if (row_q == LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            base_x_d = {3'b000, slot_tx_q} * 8'(TILE);
            base_y_d = {2'b00, slot_ty_q} * 7'(TILE);
            shape_d  = slot_shape_q;
            fg_d     = slot_colour_q;
            erase_d  = slot_erase_q;
            row_d    = 3'd0;
            col_d    = 3'd0;
            state_d  = in_range ? S_DRAW : S_IDLE;
            err_d    = ~in_range;
        end

        // Pixel coordinates and colour only move on a plotted cycle.
        if (plot_d) begin
            x_d          = base_x_q + {5'b00000, col_q};
            y_d          = base_y_q + {4'b0000, row_q};
            pix_colour_d = (shape_q[NPIX-1] & ~erase_q) ? fg_q : 3'b000;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            row_q         <= 3'd0;
            col_q         <= 3'd0;
            base_x_q      <= 8'd0;
            base_y_q      <= 7'd0;
            shape_q       <= '0;
            fg_q          <= 3'd0;
            erase_q       <= 1'b0;
            slot_full_q   <= 1'b0;
            slot_tx_q     <= 5'd0;
            slot_ty_q     <= 5'd0;
            slot_shape_q  <= '0;
            slot_colour_q <= 3'd0;
            slot_erase_q  <= 1'b0;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            pix_colour_q  <= 3'd0;
            plot_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            shape_q       <= shape_d;
            fg_q          <= fg_d;
            erase_q       <= erase_d;
            slot_full_q   <= slot_full_d;
            slot_tx_q     <= slot_tx_d;
            slot_ty_q     <= slot_ty_d;
            slot_shape_q  <= slot_shape_d;
            slot_colour_q <= slot_colour_d;
            slot_erase_q  <= slot_erase_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_colour_q  <= pix_colour_d;
            plot_q        <= plot_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready = ~slot_full_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = pix_colour_q;
    assign bus.plot_en   = plot_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = err_q;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Randomized bench for sprite_draw_engine: a cycle timeline of expected plots, done and
// cmd_err is built from each accepted command and compared against the DUT every cycle.
module tb_sprite_draw_engine;
    localparam int NC = 8192;
`ifdef SPRITE_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #10 clock = ~clock;

    sprite_draw_engine_if bus_if();

    sprite_draw_engine dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    bit         exp_plot [NC];
    logic [7:0] exp_x    [NC];
    logic [6:0] exp_y    [NC];
    logic [2:0] exp_c    [NC];
    bit         exp_done [NC];
    bit         exp_err  [NC];

    int  free_at = 1;
    bit  pend    = 1'b0;
    int  pend_a  = 0;
    int  pend_p  = 0;
    logic [7:0] last_x = 8'd0;
    logic [6:0] last_y = 7'd0;
    logic [2:0] last_c = 3'd0;
    bit  accepted = 1'b0;
    int  acc_cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // The slot is occupied from the cycle after acceptance through the cycle it is popped.
    function automatic bit model_ready(input int c);
        return !(pend && c > pend_a && c <= pend_p);
    endfunction

    task automatic model_reset(input int r);
        for (int c = r + 1; c < NC; c++) begin
            exp_plot[c] = 1'b0;
            exp_done[c] = 1'b0;
            exp_err[c]  = 1'b0;
        end
        free_at = r + 1;
        pend    = 1'b0;
        last_x  = 8'd0;
        last_y  = 7'd0;
        last_c  = 3'd0;
    endtask

    task automatic model_accept(input int a, input logic [4:0] tx, input logic [4:0] ty,
                                input logic [24:0] shape, input logic [2:0] col, input logic erase);
        int p;
        p = (a + 1 > free_at) ? a + 1 : free_at;
        pend   = 1'b1;
        pend_a = a;
        pend_p = p;
        if (int'(tx) > 31 || int'(ty) > 23) begin
            exp_err[p + 1] = 1'b1;
            free_at = p + 1;
        end else begin
            for (int k = 0; k < 25; k++) begin
                int  c;
                bit  b;
                c = p + 2 + k;
                b = shape[24 - k];
                exp_plot[c] = TRANSP ? (erase || b) : 1'b1;
                exp_x[c]    = 8'(int'(tx) * 5 + k % 5);
                exp_y[c]    = 7'(int'(ty) * 5 + k / 5);
                exp_c[c]    = (erase || !b) ? 3'b000 : col;
            end
            exp_done[p + 27] = 1'b1;
            free_at = p + 26;
        end
    endtask

    task automatic check_cycle(input int c);
        chk("cmd_ready", 32'(bus_if.cmd_ready), 32'(model_ready(c)));
        chk("plot_en",   32'(bus_if.plot_en),   32'(exp_plot[c]));
        chk("done",      32'(bus_if.done),      32'(exp_done[c]));
        chk("cmd_err",   32'(bus_if.cmd_err),   32'(exp_err[c]));
        if (exp_plot[c]) begin
            last_x = exp_x[c];
            last_y = exp_y[c];
            last_c = exp_c[c];
        end
        chk("x",      32'(bus_if.x),      32'(last_x));
        chk("y",      32'(bus_if.y),      32'(last_y));
        chk("colour", 32'(bus_if.colour), 32'(last_c));
    endtask

    task automatic tick();
        @(negedge clock);
        if (chk_en) check_cycle(cyc);
        if (!reset_n) begin
            model_reset(cyc);
            chk_en = 1'b1;
        end else if (bus_if.cmd_valid && model_ready(cyc)) begin
            model_accept(cyc, bus_if.cmd_tx, bus_if.cmd_ty, bus_if.cmd_shape,
                         bus_if.cmd_colour, bus_if.cmd_erase);
            accepted = 1'b1;
            acc_cyc  = cyc;
            $display("cmd cyc=%0d tx=%0d ty=%0d shape=%07h colour=%0d erase=%0d",
                     cyc, bus_if.cmd_tx, bus_if.cmd_ty, bus_if.cmd_shape,
                     bus_if.cmd_colour, bus_if.cmd_erase);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [4:0] tx, input logic [4:0] ty, input logic [24:0] shape,
                         input logic [2:0] col, input logic erase);
        bus_if.cmd_valid  = 1'b1;
        bus_if.cmd_tx     = tx;
        bus_if.cmd_ty     = ty;
        bus_if.cmd_shape  = shape;
        bus_if.cmd_colour = col;
        bus_if.cmd_erase  = erase;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) tick();
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_tx     = 5'd0;
        bus_if.cmd_ty     = 5'd0;
        bus_if.cmd_shape  = 25'd0;
        bus_if.cmd_colour = 3'd0;
        bus_if.cmd_erase  = 1'b0;
        @(posedge clock);
        #1;

        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        idle(3);

        issue(5'd2, 5'd3, 25'h1FFFFFF, 3'b110, 1'b0);
        idle(35);
        issue(5'd9, 5'd4, 25'h1000001, 3'b010, 1'b0);
        idle(35);
        issue(5'd5, 5'd7, 25'h1FFFFFF, 3'b011, 1'b1);
        idle(35);

        issue(5'd1, 5'd1, 25'($urandom()), 3'b101, 1'b0);
        issue(5'd4, 5'd4, 25'($urandom()), 3'b111, 1'b0);
        idle(60);

        issue(5'd31, 5'd23, 25'h1FFFFFF, 3'b001, 1'b0);
        idle(35);
        issue(5'd3, 5'd24, 25'h1FFFFFF, 3'b001, 1'b0);
        idle(6);
        issue(5'd0, 5'd0, 25'h0AAAAAA, 3'b100, 1'b0);
        idle(35);

        issue(5'd6, 5'd6, 25'h1FFFFFF, 3'b010, 1'b0);
        t0 = acc_cyc;
        issue(5'd7, 5'd7, 25'h1FFFFFF, 3'b011, 1'b0);
        bus_if.cmd_valid = 1'b0;
        while (cyc < t0 + 10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle(40);

        for (int n = 0; n < 40 && cyc < NC - 400; n++) begin
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 26)), 25'($urandom()),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 30));
        end
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
